udc_sequencer: RTL and testbench
================================

UDC_SEQUENCER -- requirements
Module: udc_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'd4096, maximum cycles spent in RUN waiting for ec.
REQ-002 SHALL have port clk, input, 1, sole clock; all flops on posedge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port req, input, 1, host request to configure and run the counter.
REQ-005 SHALL have ports plr_in, ulr_in, llr_in, ccr_in, input, 8 each, host register values; captured when req is accepted.
REQ-006 SHALL have port busy, output, 1, high from acceptance through DONE.
REQ-007 SHALL have port done, output, 1, one-cycle pulse at sequence end, success or error.
REQ-008 SHALL have port err_code, output, 2, meaning 00 ok, 01 range, 10 readback mismatch, 11 timeout; valid with done and held until next acceptance.
REQ-009 SHALL have ports ncs, nwr, nrd, output, 1 each, active-low counter bus strobes.
REQ-010 SHALL have ports A1, A0, output, 1 each, register select: 00 PLR, 01 ULR, 10 LLR, 11 CCR.
REQ-011 SHALL have ports bus_dout, output, 8, and bus_oe, output, 1, write data and drive enable; tristating is external.
REQ-012 SHALL have port bus_din, input, 8, read data from the counter.
REQ-013 SHALL have port udc_reset_n, output, 1, active-low reset driven to the counter.
REQ-014 SHALL have port start_out, output, 1, counter start pulse.
REQ-015 SHALL have port ec, input, 1, counter end-cycle indication.

Function
REQ-016 SHALL implement states IDLE, CHECK, CLR, WR, RD, START, RUN, DONE.
REQ-017 In IDLE, req=1 at a posedge SHALL capture the four inputs, set busy=1 next cycle, and go to CHECK; req while busy SHALL be ignored.
REQ-018 CHECK, 1 cycle: if llr>plr or plr>ulr, SHALL go to DONE with err_code=01 and no bus activity; otherwise SHALL go to CLR.
REQ-019 CLR SHALL hold ncs=0 and udc_reset_n=0 for 2 cycles, then release udc_reset_n=1.
REQ-020 WR SHALL write PLR, ULR, LLR, CCR in that order; each write SHALL be 1 strobe cycle (ncs=0, nwr=0, nrd=1, bus_oe=1, address and data stable) followed by 1 gap cycle (ncs=0, nwr=1, nrd=1, bus_oe=0).
REQ-021 nwr and nrd SHALL never be low in the same cycle; bus_oe SHALL be 1 only while nwr=0.
REQ-022 START, entered after writes (and readback when enabled): if ccr=0, SHALL go to DONE with err_code=00 and no start_out; otherwise SHALL drive start_out=1 for exactly 1 cycle, then enter RUN.
REQ-023 RUN SHALL hold ncs=0, nwr=nrd=1, and count cycles in a 16-bit counter; ec=1 SHALL go to DONE with 00; count reaching TIMEOUT_CYCLES SHALL go to DONE with 11; ec and timeout in the same cycle SHALL resolve as ec.
REQ-024 DONE SHALL pulse done for 1 cycle, drop busy the cycle after, and return to IDLE; ncs SHALL be 1 in IDLE and DONE.
REQ-025 Sequence latency with ccr>0 and readback disabled SHALL be req to start_out = 12 cycles (1 CHECK + 2 CLR + 8 WR + 1 START entry).

Reset
REQ-026 reset=1 SHALL asynchronously force IDLE, busy=0, done=0, err_code=00, ncs=nwr=nrd=1, A1=A0=0, bus_dout=0, bus_oe=0, start_out=0, udc_reset_n=0, and clear captured values and the timeout counter.
REQ-027 After reset release, udc_reset_n SHALL go to 1 on the first posedge; reset mid-sequence SHALL abandon the sequence without a done pulse.

Configuration
REQ-028 Macro UDC_READBACK_EN defined: after WR, state RD SHALL read each register in order (1 cycle ncs=0, nrd=0; bus_din sampled at that posedge; 1 gap cycle), and any mismatch SHALL go to DONE with 10 and no start_out; this adds 8 cycles of latency (20 total).
REQ-029 Macro UDC_READBACK_EN undefined: RD SHALL be absent, nrd SHALL stay 1 at all times, and 10 SHALL never be reported.

Verification
REQ-030 plr=5, ulr=10, llr=2, ccr=2, req pulse; ec at 40 cycles after start_out -> writes 05,0A,02,02 at addresses 00,01,10,11; start_out 1 cycle; done with 00.
REQ-031 plr=12, ulr=10, llr=2 -> done within 3 cycles with 01; ncs never 0; no start_out.
REQ-032 ccr=0 with a valid range -> four writes occur, no start_out, done with 00.
REQ-033 TIMEOUT_CYCLES=100, ec held 0 -> done exactly 100 cycles after RUN entry with 11.
REQ-034 UDC_READBACK_EN defined, bus_din returns 0x07 for PLR=0x05 -> done with 10; no start_out.
REQ-035 reset asserted during WR of ULR -> all outputs immediately at reset values; no done pulse; next req completes normally.

Source files
------------

// File: rtl/udc_sequencer.sv
// udc_sequencer: host-side sequencer that clears, programs, optionally verifies and runs an up/down counter
// Ports: clk, reset (async active-high); req with plr_in/ulr_in/llr_in/ccr_in from the host;
//   busy/done/err_code status (00 ok, 01 range, 10 readback mismatch, 11 timeout);
//   ncs/nwr/nrd/A1/A0/bus_dout/bus_oe/bus_din counter bus; udc_reset_n, start_out, ec counter control.
// Define UDC_READBACK_EN to read back and verify every written register before starting the counter.
module udc_sequencer #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [7:0] plr_in,
    input  logic [7:0] ulr_in,
    input  logic [7:0] llr_in,
    input  logic [7:0] ccr_in,
    output logic       busy,
    output logic       done,
    output logic [1:0] err_code,
    output logic       ncs,
    output logic       nwr,
    output logic       nrd,
    output logic       A1,
    output logic       A0,
    output logic [7:0] bus_dout,
    output logic       bus_oe,
    input  logic [7:0] bus_din,
    output logic       udc_reset_n,
    output logic       start_out,
    input  logic       ec
);
    typedef enum logic [2:0] {IDLE, CHECK, CLR, WR, RD, START, RUN, DONE} state_t;
    state_t      state;
    logic [7:0]  cap [4];
    logic [2:0]  step;
    logic [15:0] cnt;
    logic [1:0]  nxt;
    assign nxt = step[2:1] + 2'd1;
`ifndef UDC_READBACK_EN
    logic unused_din;
    assign unused_din = ^bus_din;
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_code    <= 2'b00;
            ncs         <= 1'b1;
            nwr         <= 1'b1;
            nrd         <= 1'b1;
            {A1, A0}    <= 2'b00;
            bus_dout    <= 8'h00;
            bus_oe      <= 1'b0;
            start_out   <= 1'b0;
            udc_reset_n <= 1'b0;
            cap         <= '{default: 8'h00};
            step        <= 3'd0;
            cnt         <= 16'd0;
        end else begin
            done      <= 1'b0;
            start_out <= 1'b0;
            case (state)
                IDLE: begin
                    udc_reset_n <= 1'b1;
                    if (req) begin
                        cap      <= '{plr_in, ulr_in, llr_in, ccr_in};
                        busy     <= 1'b1;
                        err_code <= 2'b00;
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    // cap order: 0 PLR, 1 ULR, 2 LLR, 3 CCR; a bad range ends before the bus is touched
                    if (cap[2] > cap[0] || cap[0] > cap[1]) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        err_code <= 2'b01;
                    end else begin
                        state       <= CLR;
                        ncs         <= 1'b0;
                        udc_reset_n <= 1'b0;
                        step        <= 3'd0;
                    end
                end
                CLR: begin
                    step <= step + 3'd1;
                    if (step[0]) begin
                        // Counter reset release coincides with the PLR write strobe
                        udc_reset_n <= 1'b1;
                        state       <= WR;
                        step        <= 3'd0;
                        nwr         <= 1'b0;
                        bus_oe      <= 1'b1;
                        {A1, A0}    <= 2'b00;
                        bus_dout    <= cap[0];
                    end
                end
                WR: begin
                    // Even steps strobe, odd steps are gaps; address/data advance entering each strobe
                    step   <= step + 3'd1;
                    nwr    <= ~step[0];
                    bus_oe <= step[0];
                    if (step[0]) begin
                        {A1, A0} <= nxt;
                        bus_dout <= cap[nxt];
                    end
                    if (step == 3'd7) begin
                        nwr    <= 1'b1;
                        bus_oe <= 1'b0;
`ifdef UDC_READBACK_EN
                        state    <= RD;
                        step     <= 3'd0;
                        nrd      <= 1'b0;
                        {A1, A0} <= 2'b00;
`else
                        state     <= START;
                        start_out <= cap[3] != 8'h00;
`endif
                    end
                end
`ifdef UDC_READBACK_EN
                RD: begin
                    step <= step + 3'd1;
                    nrd  <= ~step[0];
                    if (step[0]) {A1, A0} <= nxt;
                    if (!step[0] && bus_din != cap[step[2:1]]) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        err_code <= 2'b10;
                        nrd      <= 1'b1;
                        ncs      <= 1'b1;
                    end else if (step == 3'd7) begin
                        nrd       <= 1'b1;
                        state     <= START;
                        start_out <= cap[3] != 8'h00;
                    end
                end
`endif
                START: begin
                    cnt <= 16'd0;
                    if (cap[3] != 8'h00) state <= RUN;
                    else begin
                        state <= DONE;
                        done  <= 1'b1;
                        ncs   <= 1'b1;
                    end
                end
                RUN: begin
                    cnt <= cnt + 16'd1;
                    // ec takes priority over a timeout landing on the same cycle
                    if (ec || cnt + 16'd1 == TIMEOUT_CYCLES) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        ncs      <= 1'b1;
                        err_code <= ec ? 2'b00 : 2'b11;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_udc_sequencer.sv
// tb_udc_sequencer: scoreboard bench for udc_sequencer with a latency/outcome reference model
module tb_udc_sequencer;
    localparam logic [15:0] T = 16'd100;
`ifdef UDC_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    logic clk = 1'b0, reset = 1'b1, req = 1'b0, ec = 1'b0;
    logic [7:0] plr_in = 0, ulr_in = 0, llr_in = 0, ccr_in = 0, bus_din, bus_dout;
    logic busy, done, ncs, nwr, nrd, A1, A0, bus_oe, udc_reset_n, start_out;
    logic [1:0] err_code;

    udc_sequencer #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .req(req),
        .plr_in(plr_in), .ulr_in(ulr_in), .llr_in(llr_in), .ccr_in(ccr_in),
        .busy(busy), .done(done), .err_code(err_code),
        .ncs(ncs), .nwr(nwr), .nrd(nrd), .A1(A1), .A0(A0),
        .bus_dout(bus_dout), .bus_oe(bus_oe), .bus_din(bus_din),
        .udc_reset_n(udc_reset_n), .start_out(start_out), .ec(ec)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       err;
        int               done_cyc;
        int               starts;
        int               start_cyc;
        int               clr;
        int               nw;
        logic [3:0][9:0]  w;
        bit               quiet;
    } exp_t;

    exp_t       sb[$];
    exp_t       me;
    logic [9:0] wr_obs[$];
    int n_chk = 0, n_fail = 0, cyc = 0;
    int clr_obs = 0, start_obs = 0, start_obs_cyc = 0, ncs_obs = 0;
    logic [7:0] mem [4] = '{default: 8'h00};
    int         cor_i = -1;
    logic [7:0] cor_mask = 8'h00;
    logic [1:0] last_err = 2'b00;
    logic [7:0] a, b, c, t;

    always @(posedge clk) cyc <= cyc + 1;

    // Counter-side register file; an optional corruption mask fakes a bad readback
    assign bus_din = mem[{A1, A0}] ^ ((int'({A1, A0}) == cor_i) ? cor_mask : 8'h00);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Outcome and timing derived from the documented phase lengths
    function automatic exp_t model(input logic [7:0] p, u, l, cc, input int m, input int P);
        exp_t e;
        int base;
        base = P + 12 + (RB ? 8 : 0);
        e.err = 2'b00; e.starts = 0; e.start_cyc = 0; e.clr = 2; e.nw = 4; e.quiet = 1'b0;
        e.w = {{2'd3, cc}, {2'd2, l}, {2'd1, u}, {2'd0, p}};
        if (l > p || p > u) begin
            e.err = 2'b01; e.clr = 0; e.nw = 0; e.quiet = 1'b1; e.done_cyc = P + 2;
            return e;
        end
        if (RB && cor_i >= 0 && cor_mask != 8'h00) begin
            e.err = 2'b10; e.done_cyc = P + 13 + 2 * cor_i;
            return e;
        end
        if (cc == 8'h00) begin
            e.done_cyc = base + 1;
            return e;
        end
        e.starts = 1; e.start_cyc = base;
        if (m > 0 && m <= int'(T)) e.done_cyc = base + 1 + m;
        else begin
            e.err = 2'b11; e.done_cyc = base + 1 + int'(T);
        end
        return e;
    endfunction

    // Monitor: bus rules every cycle, full outcome comparison on each done pulse
    always @(negedge clk) begin
        if (reset) begin
            wr_obs.delete(); clr_obs = 0; start_obs = 0; ncs_obs = 0;
        end else begin
            chk("bus_protocol", {28'd0, ~nwr & ~nrd, bus_oe & nwr, ~busy & ~ncs, ~RB & ~nrd}, 32'd0);
            if (!ncs && !nwr) begin
                wr_obs.push_back({A1, A0, bus_dout});
                mem[{A1, A0}] = bus_dout;
            end
            if (busy && !udc_reset_n) clr_obs++;
            if (busy && !ncs) ncs_obs++;
            if (start_out) begin
                start_obs++;
                start_obs_cyc = cyc;
            end
            if (done) begin
                if (sb.size() == 0) chk("unexpected_done", sb.size(), 1);
                else begin
                    me = sb.pop_front();
                    chk("err_code", err_code, me.err);
                    chk("done_cycle", cyc, me.done_cyc);
                    chk("start_pulses", start_obs, me.starts);
                    if (me.starts == 1 && start_obs == 1) chk("start_cycle", start_obs_cyc, me.start_cyc);
                    chk("clr_cycles", clr_obs, me.clr);
                    chk("write_count", wr_obs.size(), me.nw);
                    if (wr_obs.size() == me.nw)
                        for (int i = 0; i < me.nw; i++) chk("write_data", wr_obs[i], me.w[i]);
                    if (me.quiet) chk("ncs_quiet", ncs_obs, 0);
                    chk("busy_ncs_at_done", {busy, ncs}, 2'b11);
                end
                wr_obs.delete(); clr_obs = 0; start_obs = 0; ncs_obs = 0;
            end
        end
    end

    task automatic run_seq(input logic [7:0] p, u, l, cc, input int m, input int hold);
        int P, ec_at;
        exp_t e;
        chk("err_held", err_code, last_err);
        @(posedge clk); #1;
        req = 1'b1; plr_in = p; ulr_in = u; llr_in = l; ccr_in = cc; P = cyc;
        e = model(p, u, l, cc, m, P);
        ec_at = P + 12 + (RB ? 8 : 0) + m;
        @(posedge clk); #1;
        sb.push_back(e);
        last_err = e.err;
        for (int i = 1; i < hold; i++) begin
            plr_in = 8'($urandom); ulr_in = 8'($urandom); llr_in = 8'($urandom); ccr_in = 8'($urandom);
            @(posedge clk); #1;
        end
        req = 1'b0;
        plr_in = 8'($urandom); ulr_in = 8'($urandom); llr_in = 8'($urandom); ccr_in = 8'($urandom);
        while (sb.size() != 0 && cyc < e.done_cyc + 4) begin
            if (m > 0 && cyc >= ec_at) ec = 1'b1;
            @(posedge clk); #1;
        end
        chk("done_seen", sb.size(), 0);
        sb.delete();
        ec = 1'b0;
        chk("busy_released", busy, 1'b0);
    endtask

    task automatic reset_check(input string tag);
        chk(tag, {busy, done, err_code, ncs, nwr, nrd, A1, A0, bus_dout, bus_oe, start_out, udc_reset_n},
            {1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("urst_before_edge", udc_reset_n, 1'b0);
        @(posedge clk); #1;
        chk("urst_after_edge", {udc_reset_n, busy}, 2'b10);
        last_err = 2'b00;
    endtask

    initial begin
        int P;
        repeat (2) @(posedge clk);
        #1 reset_check("reset_state");
        run_seq(8'd5, 8'd10, 8'd2, 8'd2, 40, 1);
        run_seq(8'd12, 8'd10, 8'd2, 8'd2, 40, 1);
        run_seq(8'd5, 8'd10, 8'd2, 8'd0, 40, 1);
        run_seq(8'd5, 8'd10, 8'd2, 8'd2, 0, 1);
        run_seq(8'd7, 8'd7, 8'd7, 8'd1, 100, 1);
        run_seq(8'd0, 8'd255, 8'd0, 8'd9, 101, 1);
        run_seq(8'd3, 8'd9, 8'd1, 8'd4, 20, 4);
        run_seq(8'd4, 8'd3, 8'd1, 8'd1, 5, 1);
`ifdef UDC_READBACK_EN
        cor_i = 0; cor_mask = 8'h02;
        run_seq(8'd5, 8'd10, 8'd2, 8'd2, 40, 1);
        cor_i = 3; cor_mask = 8'h80;
        run_seq(8'd5, 8'd10, 8'd2, 8'd2, 40, 1);
        cor_i = -1; cor_mask = 8'h00;
`endif
        @(posedge clk); #1;
        req = 1'b1; plr_in = 8'd5; ulr_in = 8'd10; llr_in = 8'd2; ccr_in = 8'd2; P = cyc;
        @(posedge clk); #1;
        req = 1'b0;
        while (cyc < P + 6) begin
            @(posedge clk); #1;
        end
        chk("ulr_strobe", {nwr, A1, A0, bus_dout}, {1'b0, 2'b01, 8'h0A});
        #2 reset = 1'b1;
        #1 reset_check("reset_mid_write");
        run_seq(8'd5, 8'd10, 8'd2, 8'd2, 40, 1);
        for (int k = 0; k < 24; k++) begin
            a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
            if ($urandom_range(3) != 0) begin
                if (a > b) begin t = a; a = b; b = t; end
                if (b > c) begin t = b; b = c; c = t; end
                if (a > b) begin t = a; a = b; b = t; end
                run_seq(b, c, a, ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom_range(255, 1)),
                        int'($urandom_range(130)), int'($urandom_range(3, 1)));
            end else
                run_seq(a, b, c, 8'($urandom), int'($urandom_range(130)), 1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end
endmodule
